// File: rtl/regfile_readback_checker.sv
// Read-side register-file checker: scans every address, compares against the writer's
// seed pattern and reports pass/fail, error count, first failure and last word read.
//
// state | meaning
// IDLE  | waiting for start, bus released
// ADDR  | address presented, read enable asserted
// WAIT  | waiting out the remaining read latency
// CHECK | sample rd_data, compare, advance or finish
// DONE  | results frozen until the next start
module regfile_readback_checker #(
  parameter int          NUM_REGS     = 32,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SEED_LO      = 32'hFFFF000F,
  parameter logic [31:0] SEED_HI      = 32'h0000FFF0,
  localparam int         AW           = $clog2(NUM_REGS)
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [31:0]   rd_data_i,
  output logic          re_o,
  output logic          we_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [AW:0]   err_count_o,
  output logic [AW-1:0] first_err_addr_o,
  output logic [31:0]   first_err_data_o,
  output logic [31:0]   last_data_o
);

  localparam int WW = $clog2(READ_LATENCY + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          re_q, re_d;
  logic          done_q, done_d;
  logic [AW:0]   err_q, err_d;
  logic [AW-1:0] fea_q, fea_d;
  logic [31:0]   fed_q, fed_d;
  logic [31:0]   last_q, last_d;
  logic          mismatch;

  // Lower half counts down from SEED_LO, upper half counts up from SEED_HI.
  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a & AW'(NUM_REGS / 2 - 1);
    if (a < AW'(NUM_REGS / 2)) return SEED_LO - 32'(a);
    else return SEED_HI + 32'(off);
  endfunction

  assign mismatch = (rd_data_i != exp_word(addr_q));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    re_d    = re_q;
    done_d  = done_q;
    err_d   = err_q;
    fea_d   = fea_q;
    fed_d   = fed_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_ADDR;
          addr_d  = '0;
          re_d    = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          fea_d   = '0;
          fed_d   = '0;
        end
      end
      S_ADDR: begin
        if (READ_LATENCY > 1) begin
          state_d = S_WAIT;
          wait_d  = WW'(READ_LATENCY - 2);
        end else begin
          state_d = S_CHECK;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CHECK;
        else wait_d = wait_q - 1'b1;
      end
      S_CHECK: begin
        last_d = rd_data_i;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fea_d = addr_q;
            fed_d = rd_data_i;
          end
        end
        if (addr_q == AW'(NUM_REGS - 1)) begin
          state_d = S_DONE;
          re_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ADDR;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        re_d    = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      re_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      re_q    <= re_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      fed_q   <= fed_d;
      last_q  <= last_d;
    end
  end

  // re and busy are asserted over exactly the same states, so they share one flop.
  assign re_o             = re_q;
  assign busy_o           = re_q;
  assign we_o             = 1'b0;
  assign rd_addr_o        = addr_q;
  assign done_o           = done_q;
  assign pass_o           = done_q && (err_q == '0);
  assign err_count_o      = err_q;
  assign first_err_addr_o = fea_q;
  assign first_err_data_o = fed_q;
  assign last_data_o      = last_q;

endmodule
